// File: rtl/demux1x8_deser.sv
// demux1x8_deser: serial-to-parallel demultiplexer.
// Each valid input bit is written into one of eight slots chosen by a 3-bit
// slot counter. When the eighth bit arrives, the assembled byte is published
// on a registered output, together with a one-cycle valid pulse. A sync strobe
// realigns the counter to slot 0. All outputs come directly from flops.
module demux1x8_deser #(
  parameter int MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync,
  input  logic       din,
  input  logic       din_valid,
  output logic [7:0] dataout,
  output logic       dataout_valid,
  output logic [2:0] slot
);

  // Maps a slot number to a bit position in the byte (bit order per MSB_FIRST).
  function automatic logic [2:0] slot_to_idx(input logic [2:0] s);
    if (MSB_FIRST != 0) begin
      return 3'd7 - s;
    end else begin
      return s;
    end
  endfunction

  logic [2:0] slot_r;
  logic [7:0] shadow_r;
  logic [7:0] dataout_r;
  logic       dataout_valid_r;

  logic [2:0] eff_slot_s;
  logic [2:0] idx_s;
  logic [7:0] merged_s;
  logic       complete_s;

  // Slot the current bit lands in (sync restarts the frame), plus the shadow
  // byte with that bit merged in, and detection of byte completion.
  always_comb begin
    eff_slot_s = slot_r;
    merged_s   = shadow_r;
    if (sync) begin
      eff_slot_s = 3'd0;
    end else begin
      eff_slot_s = slot_r;
    end
    idx_s            = slot_to_idx(eff_slot_s);
    merged_s[idx_s]  = din;
    complete_s       = din_valid & ~sync & (slot_r == 3'd7);
  end

  // Slot counter, shadow capture and publication of completed bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_r          <= 3'd0;
      shadow_r        <= 8'h00;
      dataout_r       <= 8'h00;
      dataout_valid_r <= 1'b0;
    end else begin
      dataout_valid_r <= 1'b0;
      if (din_valid) begin
        shadow_r <= merged_s;
        slot_r   <= eff_slot_s + 3'd1;
        if (complete_s) begin
          dataout_r       <= merged_s;
          dataout_valid_r <= 1'b1;
        end
      end else if (sync) begin
        slot_r <= 3'd0;
      end
    end
  end

  assign dataout       = dataout_r;
  assign dataout_valid = dataout_valid_r;
  assign slot          = slot_r;

endmodule

// File: tb/tb_demux1x8_deser.sv
// Directed testbench for demux1x8_deser. It drives one LSB-first instance and
// one MSB-first instance from the same stimulus and checks both.
module tb_demux1x8_deser;

  logic       clk;
  logic       rst_n;
  logic       sync;
  logic       din;
  logic       din_valid;
  logic [7:0] dataout_l;
  logic       dataout_valid_l;
  logic [2:0] slot_l;
  logic [7:0] dataout_m;
  logic       dataout_valid_m;
  logic [2:0] slot_m;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_l;
  logic [7:0] exp_m;
  logic [7:0] pat;

  demux1x8_deser #(.MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .sync(sync), .din(din), .din_valid(din_valid),
    .dataout(dataout_l), .dataout_valid(dataout_valid_l), .slot(slot_l)
  );

  demux1x8_deser #(.MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .sync(sync), .din(din), .din_valid(din_valid),
    .dataout(dataout_m), .dataout_valid(dataout_valid_m), .slot(slot_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks both instances: shared slot/valid expectations, per-instance data.
  task automatic chk_all(input string tag, input logic [2:0] es, input logic ev,
                         input logic [7:0] edl, input logic [7:0] edm);
    chk({tag, "_slot_l"},  {5'd0, slot_l}, {5'd0, es});
    chk({tag, "_slot_m"},  {5'd0, slot_m}, {5'd0, es});
    chk({tag, "_valid_l"}, {7'd0, dataout_valid_l}, {7'd0, ev});
    chk({tag, "_valid_m"}, {7'd0, dataout_valid_m}, {7'd0, ev});
    chk({tag, "_data_l"},  dataout_l, edl);
    chk({tag, "_data_m"},  dataout_m, edm);
  endtask

  // Applies the inputs for one cycle, then returns 1 time unit after the edge.
  task automatic cyc(input logic s, input logic v, input logic d);
    sync = s; din_valid = v; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; sync = 1'b0; din = 1'b1; din_valid = 1'b1;

    // Reset held for 2 cycles with valid data present
    cyc(1'b0, 1'b1, 1'b1);
    chk_all("rst0", 3'd0, 1'b0, 8'h00, 8'h00);
    cyc(1'b0, 1'b1, 1'b1);
    chk_all("rst1", 3'd0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk_all("rst_rel", 3'd0, 1'b0, 8'h00, 8'h00);

    // Sync pulse, then bits 1,1,0,1,0,0,0,0 -> 0B (LSB first) / D0 (MSB first)
    cyc(1'b1, 1'b0, 1'b0);
    chk_all("sync_idle", 3'd0, 1'b0, 8'h00, 8'h00);
    pat = 8'b0000_1011;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, pat[i]);
      if (i < 7) chk_all("b0_bit", 3'(i + 1), 1'b0, 8'h00, 8'h00);
    end
    chk_all("b0_done", 3'd0, 1'b1, 8'h0B, 8'hD0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_all("b0_after", 3'd0, 1'b0, 8'h0B, 8'hD0);

    // A5 with 3-cycle gaps after the 2nd and 5th bits; A5 is bit-palindromic
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, pat[i]);
      if (i < 7) chk_all("a5_bit", 3'(i + 1), 1'b0, 8'h0B, 8'hD0);
      if (i == 1 || i == 4) begin
        for (int g = 0; g < 3; g++) begin
          cyc(1'b0, 1'b0, 1'b1);
          chk_all("a5_gap", 3'(i + 1), 1'b0, 8'h0B, 8'hD0);
        end
      end
    end
    chk_all("a5_done", 3'd0, 1'b1, 8'hA5, 8'hA5);

    // 3C back to back; completes exactly 8 cycles after A5
    pat = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, pat[i]);
      if (i < 7) chk_all("3c_bit", 3'(i + 1), 1'b0, 8'hA5, 8'hA5);
    end
    chk_all("3c_done", 3'd0, 1'b1, 8'h3C, 8'h3C);
    cyc(1'b0, 1'b0, 1'b0);
    chk_all("3c_after", 3'd0, 1'b0, 8'h3C, 8'h3C);

    // Resync mid-frame: 5 zero bits, sync+valid with 1, then 7 ones -> FF
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk_all("rs_pre", 3'(i + 1), 1'b0, 8'h3C, 8'h3C);
    end
    cyc(1'b1, 1'b1, 1'b1);
    chk_all("rs_sync", 3'd1, 1'b0, 8'h3C, 8'h3C);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (i < 6) chk_all("rs_bit", 3'(i + 2), 1'b0, 8'h3C, 8'h3C);
    end
    chk_all("rs_done", 3'd0, 1'b1, 8'hFF, 8'hFF);
    cyc(1'b0, 1'b0, 1'b0);
    chk_all("rs_after", 3'd0, 1'b0, 8'hFF, 8'hFF);

    // Sync without valid mid-frame returns slot to 0
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    chk_all("sv_pre", 3'd3, 1'b0, 8'hFF, 8'hFF);
    cyc(1'b1, 1'b0, 1'b0);
    chk_all("sv_sync", 3'd0, 1'b0, 8'hFF, 8'hFF);

    // Reset mid-frame: 6 bits, 1-cycle reset, then 81
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1);
    chk_all("rm_pre", 3'd6, 1'b0, 8'hFF, 8'hFF);
    rst_n = 1'b0;
    cyc(1'b0, 1'b1, 1'b1);
    chk_all("rm_rst", 3'd0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    pat = 8'h81;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, pat[i]);
      if (i < 7) chk_all("81_bit", 3'(i + 1), 1'b0, 8'h00, 8'h00);
    end
    chk_all("81_done", 3'd0, 1'b1, 8'h81, 8'h81);

    // Sync coinciding with the 8th bit: no completion, bit becomes slot 0
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b1);
    chk_all("s8_pre", 3'd7, 1'b0, 8'h81, 8'h81);
    cyc(1'b1, 1'b1, 1'b1);
    chk_all("s8_sync", 3'd1, 1'b0, 8'h81, 8'h81);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0);
    chk_all("s8_done", 3'd0, 1'b1, 8'h01, 8'h80);
    cyc(1'b0, 1'b0, 1'b0);
    chk_all("s8_after", 3'd0, 1'b0, 8'h01, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux1x8_deser.md
# demux1x8_deser

Serial-to-parallel demultiplexer: steers each valid input bit into one of eight slot positions selected by an internal 3-bit slot counter, then presents the assembled byte on a registered 8-bit output with a one-cycle valid pulse. It is the receive-side counterpart of the counter-driven 8:1 mux serializer in the combinational mux library. It converts a 1-bit stream back into `datain`-style 8-bit words for downstream 16:1 and 8:1 mux stages.

## Interface
Parameters:
- `MSB_FIRST`, default 0: 0 writes slot k to bit k (first bit → bit 0); 1 writes slot k to bit 7-k (first bit → bit 7).

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `sync`  input  1  frame-start strobe; forces alignment to slot 0.
- `din`  input  1  serial data bit.
- `din_valid`  input  1  `din` is sampled this cycle when high.
- `dataout`  output  8  last completed byte; registered.
- `dataout_valid`  output  1  one-cycle pulse, high in the cycle after a byte completes.
- `slot`  output  3  current slot counter, i.e. the index the next valid bit will be written to.

## Operation
- State:
  - `slot` counter, 0..7.
  - 8-bit shadow register.
  - `dataout` register.
  - `dataout_valid` flag.
- Reset (`rst_n`=0 at a clock edge): `slot`=0, shadow=8'h00, `dataout`=8'h00, `dataout_valid`=0. Reset overrides `sync` and `din_valid`. A partial frame in progress is discarded.
- Bit capture, `din_valid`=1 and `sync`=0:
  - shadow[idx] <= `din`, where idx = `slot` (MSB_FIRST=0) or 7-`slot` (MSB_FIRST=1).
  - `slot` <= `slot`+1, wrapping 7→0.
- Byte completion, `din_valid`=1 and `slot`=7:
  - `dataout` <= shadow with the current bit merged in at idx.
  - `dataout_valid` <= 1.
  - `slot` wraps to 0.
- All other cycles: `dataout_valid` <= 0 and `dataout` holds its value.
- Idle gaps (`din_valid`=0) of any length are allowed mid-frame; `slot` and shadow hold.
- `sync`=1, `din_valid`=0: `slot` <= 0, shadow unchanged, no output update.
- `sync`=1, `din_valid`=1: the bit is treated as slot 0 of the new frame. It is written to idx for slot 0 and `slot` <= 1. The aborted partial frame never produces `dataout_valid`.
- `sync` in the same cycle as what would be the 8th bit: `sync` wins. No completion occurs, the bit becomes slot 0, and `slot` <= 1.
- Shadow bits are not cleared between frames; every bit is overwritten before the next completion.
- No backpressure. A consumer must take `dataout` during the `dataout_valid` cycle. `dataout` remains stable until the next completion, at least 8 cycles later.

## Timing
- Latency: the 8th valid bit is sampled at edge N. `dataout` and `dataout_valid`=1 are visible after edge N, in cycle N+1.
- `dataout_valid` deasserts after edge N+1 unless another byte completes. The minimum spacing between pulses is 8 cycles.
- Maximum throughput: one byte per 8 cycles with `din_valid` held high. Valid pulses then occur every 8th cycle with no bubbles.
- `slot` reflects the count after each edge. With continuous valid bits it reads 0,1,…,7,0.
- All outputs are driven directly from flops. There is no combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `din_valid`=1 and `din`=1 → `slot`=0, `dataout`=8'h00, `dataout_valid`=0 throughout and for 1 cycle after release.
- LSB-first byte: MSB_FIRST=0, pulse `sync`, then feed bits 1,1,0,1,0,0,0,0 on consecutive cycles → `dataout`=8'h0B with a single-cycle `dataout_valid` one cycle after the 8th bit.
- MSB-first byte: MSB_FIRST=1, same bit sequence → `dataout`=8'hD0.
- Gapped input plus back-to-back frames: MSB_FIRST=0, byte 8'hA5 with `din_valid` low for 3 cycles after bits 2 and 5, immediately followed by 8'h3C continuous → 8'hA5 is output, then 8'h3C exactly 8 cycles later. `dataout` holds 8'hA5 in between.
- Resync mid-frame: feed 5 bits, then assert `sync` together with `din_valid`, then 7 more bits forming 8'hFF → only one `dataout_valid` pulse occurs, with `dataout`=8'hFF. `slot` reads 1 after the sync edge.
- Reset mid-frame: feed 6 bits, assert `rst_n`=0 for 1 cycle, then feed 8 bits of 8'h81 → no pulse from the partial frame, `dataout`=8'h81 at completion.
